rconst_lfsr: RTL
================

// Module: rconst_lfsr
// PURPOSE
//  Sequential Keccak-f[b] round-constant generator for lane widths 8..64.
//  Produces RC[ir] from the spec LFSR x^8+x^6+x^5+x^4+1, seven LFSR steps per round.
//  Replaces the one-hot round-index decoder in the round datapath.
//  The permutation controller steps it with start/next; it outputs a registered
//  lane-wide constant together with the round index and a last-round flag.
// PARAMETERS
//  LANE_W  64  lane width w; legal values are 8, 16, 32 and 64.
//              L = log2(LANE_W); NROUNDS = 12 + 2L.
//  IDX_W   5   width of round_idx; must satisfy 2**IDX_W >= NROUNDS.
// PORTS
//  clk        in   1        clock; everything is on the rising edge
//  reset      in   1        synchronous, active-high
//  start      in   1        begin a new permutation; loads RC[0]
//  next       in   1        advance to the next round constant
//  rc         out  LANE_W   round constant for the current round (registered)
//  round_idx  out  IDX_W    index ir of the current rc
//  valid      out  1        rc and round_idx are meaningful
//  last       out  1        valid and round_idx == NROUNDS-1
//  busy       out  1        FSM is in RUN
// BEHAVIOUR
//  Interface: one clock, clk. reset is synchronous and active-high.
//  Reset values:
//   - rc = 0, round_idx = 0, valid = 0, last = 0, busy = 0.
//   - FSM = IDLE; internal LFSR state R = 8'h01.
//  LFSR step (8-bit R):
//   - fb = R[7]; R = {R[6:0], 1'b0};
//   - if fb: R[0], R[4], R[5], R[6] are each XORed with 1.
//   - The output bit of a step is R[0] taken before the step.
//  Round function RCF(R):
//   - Apply 7 steps combinationally, giving output bits b0..b6.
//   - rc[2^j - 1] = b_j for j = 0..L; all other rc bits are 0.
//   - Bits b_(L+1)..b6 are discarded.
//   - Next R is the state after the 7 steps.
//  FSM states: IDLE and RUN.
//  start (accepted in any state; takes priority over next):
//   - rc <= RCF(8'h01).rc; R <= RCF(8'h01).R.
//   - round_idx <= 0; valid <= 1; FSM <= RUN.
//   - In RUN this aborts the current sequence.
//  next in RUN with !last:
//   - rc <= RCF(R).rc; R <= RCF(R).R; round_idx <= round_idx + 1.
//  next in RUN with last:
//   - valid <= 0; FSM <= IDLE; R <= 8'h01.
//   - rc and round_idx hold their values.
//  next in IDLE: ignored.
//  Otherwise: all registers hold.
//  Latency: rc is updated exactly 1 cycle after start or next is sampled.
//  last is combinational from the registered valid and round_idx.
//  busy == (FSM == RUN) == valid.
//  Reset asserted mid-sequence: all outputs and R return to their reset values
//   on the next edge; start/next in that same cycle are ignored.
//  round_idx never exceeds NROUNDS-1; there is no wrap-around.
// TESTING
//  1. LANE_W=64; reset, start, then next x23:
//     - rc sequence matches the FIPS-202 table:
//       RC[0]=64'h1, RC[1]=64'h8082, RC[2]=64'h800000000000808A,
//       RC[23]=64'h8000000080008008.
//     - last is high only when round_idx == 23.
//  2. LANE_W=8; start, then next x17:
//     - 18 rounds; RC[1]=8'h82, RC[9]=8'h88, RC[17]=8'h80.
//     - last is high at round_idx 17.
//     - one further next drops valid and busy to 0.
//  3. LANE_W=64; start, next x5 (rc=64'h80000001), then start:
//     - 1 cycle later rc=64'h1 and round_idx=0.
//     - The full sequence then repeats correctly.
//  4. start and next asserted together in RUN at round 7:
//     - start wins: rc=64'h1, round_idx=0.
//  5. reset asserted at round 10 together with next:
//     - next cycle: rc=0, valid=0, busy=0.
//     - A following start yields RC[0].
//  6. Held and illegal inputs:
//     - next pulsed while IDLE: no output change.
//     - Gaps of idle cycles between nexts in RUN: rc/round_idx stay stable
//       and the sequence is unchanged.

Source files
------------

// File: rtl/rconst_lfsr_if.sv
// Round-constant generator bus: the permutation controller (master) steps the generator
// (slave) with start/next and reads back the registered constant and round status.
interface rconst_lfsr_if #(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned IDX_W  = 5
);
    logic              start;
    logic              next;
    logic [LANE_W-1:0] rc;
    logic [IDX_W-1:0]  round_idx;
    logic              valid;
    logic              last;
    logic              busy;

    modport master (
        output start,
        output next,
        input  rc,
        input  round_idx,
        input  valid,
        input  last,
        input  busy
    );

    modport slave (
        input  start,
        input  next,
        output rc,
        output round_idx,
        output valid,
        output last,
        output busy
    );
endinterface

// File: rtl/rconst_lfsr.sv
// Sequential Keccak-f[b] round-constant generator: an 8-bit LFSR (x^8+x^6+x^5+x^4+1)
// advanced seven steps per round, expanded into a lane-wide registered round constant.
module rconst_lfsr #(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned IDX_W  = 5
) (
    input logic          clk,
    input logic          reset,
    rconst_lfsr_if.slave bus
);
    localparam int unsigned L       = $clog2(LANE_W);
    localparam int unsigned NROUNDS = 12 + 2 * L;
    localparam logic [7:0]  RSeed   = 8'h01;
    // Taps XORed into R[0], R[4], R[5], R[6] when the shifted-out bit is set.
    localparam logic [7:0]  RTaps   = 8'h71;

    if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
        $error("rconst_lfsr: LANE_W must be 8, 16, 32 or 64");
    end
    if ((1 << IDX_W) < NROUNDS) begin : g_bad_idx
        $error("rconst_lfsr: IDX_W too narrow for NROUNDS");
    end

    typedef enum logic {StIdle, StRun} state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [6:0] b;
    } rcf_t;

    function automatic rcf_t rcf(input logic [7:0] r_in);
        rcf_t       res;
        logic [7:0] r;
        logic       fb;
        r = r_in;
        res.b = '0;
        for (int i = 0; i < 7; i++) begin
            res.b[i] = r[0];
            fb = r[7];
            r = {r[6:0], 1'b0};
            if (fb) begin
                r = r ^ RTaps;
            end
        end
        res.r = r;
        return res;
    endfunction

    // Bit b_j lands at lane position 2^j - 1; b_(L+1)..b_6 fall off the lane.
    function automatic logic [LANE_W-1:0] expand(input logic [6:0] b);
        logic [LANE_W-1:0] rc;
        rc = '0;
        for (int j = 0; j <= int'(L); j++) begin
            rc[(1 << j) - 1] = b[j];
        end
        return rc;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        r_q, r_d;
    logic [LANE_W-1:0] rc_q, rc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [7:0]        rcf_src;
    rcf_t              rcf_res;
    logic              run;
    logic              last;

    assign run     = (state_q == StRun);
    assign last    = run && (idx_q == IDX_W'(NROUNDS - 1));
    assign rcf_src = bus.start ? RSeed : r_q;
    assign rcf_res = rcf(rcf_src);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        if (bus.start) begin
            state_d = StRun;
            r_d     = rcf_res.r;
            rc_d    = expand(rcf_res.b);
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.next) begin
                        if (last) begin
                            state_d = StIdle;
                            r_d     = RSeed;
                        end else begin
                            r_d   = rcf_res.r;
                            rc_d  = expand(rcf_res.b);
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            r_q     <= RSeed;
            rc_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.rc        = rc_q;
    assign bus.round_idx = idx_q;
    assign bus.valid     = run;
    assign bus.last      = last;
    assign bus.busy      = run;

`ifndef SYNTHESIS
    a_idx_bound: assert property (@(posedge clk) disable iff (reset)
        run |-> (idx_q <= IDX_W'(NROUNDS - 1)));
    a_start_loads: assert property (@(posedge clk)
        (!reset && bus.start) |=> (run && idx_q == '0 && rc_q[0]));
    a_idle_seed: assert property (@(posedge clk) disable iff (reset)
        !run |-> (r_q == RSeed));
`endif
endmodule
